// File: rtl/uart_time_sequencer.sv
// Formats a six-digit BCD stopwatch snapshot as "MM:SS.CC" and writes it to the UART one byte at a time.
// Define UART_SEQ_CRLF_EN to end each frame with CR LF (10 bytes); otherwise it ends with LF only (9 bytes).
module uart_time_sequencer #(
   parameter logic [4:0]  ADDR_TXDATA  = 5'h08,
   parameter logic [4:0]  ADDR_CTRL    = 5'h10,
   parameter logic [4:0]  ADDR_STATUS  = 5'h18,
   parameter int unsigned GUARD_CYC    = 4,
   parameter int unsigned POLL_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] bcd_digits,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        bus_cs,
   output logic [4:0]  bus_addr,
   output logic        bus_rd,
   output logic        bus_wr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
);

   // state     | meaning
   // S_IDLE    | waiting for start, bus idle
   // S_WR_DATA | write current character to TX data register
   // S_WR_CTRL | set tx_wr in control register
   // S_WR_CLR  | clear tx_wr in control register
   // S_GUARD   | bus idle for GUARD_CYC cycles before polling
   // S_POLL    | read status register
   // S_CHECK   | evaluate tx_busy returned by the poll
   // S_DONE    | one-cycle done pulse
   typedef enum logic [2:0] {
      S_IDLE, S_WR_DATA, S_WR_CTRL, S_WR_CLR, S_GUARD, S_POLL, S_CHECK, S_DONE
   } state_t;

`ifdef UART_SEQ_CRLF_EN
   localparam logic [3:0] IDX_LAST = 4'd9;
`else
   localparam logic [3:0] IDX_LAST = 4'd8;
`endif
   localparam logic [7:0]  GUARD_LD = (GUARD_CYC == 0) ? 8'd0 : 8'(GUARD_CYC - 1);
   localparam logic [15:0] POLL_MAX = 16'(POLL_TIMEOUT);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  guard_q, guard_d;
   logic [15:0] poll_q, poll_d;
   logic [23:0] snap_q, snap_d;
   logic        error_q, error_d;
   logic        busy_q, done_q, cs_q, rd_q, wr_q;
   logic [4:0]  addr_q;
   logic [31:0] wdata_q;
   logic        rdata_unused;

   assign rdata_unused = ^bus_rdata[31:1];

   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      return (d > 4'd9) ? 8'h3F : {4'h3, d};
   endfunction

   function automatic logic [7:0] frame_char(input logic [23:0] s, input logic [3:0] i);
      logic [7:0] c;
      case (i)
         4'd0:    c = digit_ascii(s[23:20]);
         4'd1:    c = digit_ascii(s[19:16]);
         4'd2:    c = 8'h3A;
         4'd3:    c = digit_ascii(s[15:12]);
         4'd4:    c = digit_ascii(s[11:8]);
         4'd5:    c = 8'h2E;
         4'd6:    c = digit_ascii(s[7:4]);
         4'd7:    c = digit_ascii(s[3:0]);
`ifdef UART_SEQ_CRLF_EN
         4'd8:    c = 8'h0D;
         4'd9:    c = 8'h0A;
`else
         4'd8:    c = 8'h0A;
`endif
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      guard_d = guard_q;
      poll_d  = poll_q;
      snap_d  = snap_q;
      error_d = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d  = bcd_digits;
               error_d = 1'b0;
               idx_d   = 4'd0;
               poll_d  = 16'd0;
               state_d = S_WR_DATA;
            end
         end
         S_WR_DATA: state_d = S_WR_CTRL;
         S_WR_CTRL: state_d = S_WR_CLR;
         S_WR_CLR: begin
            if (GUARD_CYC == 0) begin
               state_d = S_POLL;
            end else begin
               guard_d = GUARD_LD;
               state_d = S_GUARD;
            end
         end
         S_GUARD: begin
            if (guard_q == 8'd0) state_d = S_POLL;
            else                 guard_d = guard_q - 8'd1;
         end
         S_POLL: begin
            poll_d  = poll_q + 16'd1;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (bus_rdata[0]) begin
               if (poll_q < POLL_MAX) begin
                  state_d = S_POLL;
               end else begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               poll_d = 16'd0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_WR_DATA;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are valid in the cycle the FSM occupies it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         guard_q <= 8'd0;
         poll_q  <= 16'd0;
         snap_q  <= 24'd0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= 5'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         guard_q <= guard_d;
         poll_q  <= poll_d;
         snap_q  <= snap_d;
         error_q <= error_d;
         busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
         done_q  <= (state_d == S_DONE);
         cs_q    <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= 5'd0;
         wdata_q <= 32'd0;
         case (state_d)
            S_WR_DATA: begin
               cs_q    <= 1'b1;
               wr_q    <= 1'b1;
               addr_q  <= ADDR_TXDATA;
               wdata_q <= {24'h0, frame_char(snap_d, idx_d)};
            end
            S_WR_CTRL: begin
               cs_q    <= 1'b1;
               wr_q    <= 1'b1;
               addr_q  <= ADDR_CTRL;
               wdata_q <= 32'h1;
            end
            S_WR_CLR: begin
               cs_q   <= 1'b1;
               wr_q   <= 1'b1;
               addr_q <= ADDR_CTRL;
            end
            S_POLL: begin
               cs_q   <= 1'b1;
               rd_q   <= 1'b1;
               addr_q <= ADDR_STATUS;
            end
            default: ;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign bus_cs    = cs_q;
   assign bus_addr  = addr_q;
   assign bus_rd    = rd_q;
   assign bus_wr    = wr_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_uart_time_sequencer.sv
// Bench for uart_time_sequencer: a frame-level queue model of expected bus cycles plus a UART status responder.
module tb_uart_time_sequencer;
   localparam int G  = 4;
   localparam int PT = 6;
`ifdef UART_SEQ_CRLF_EN
   localparam int FL = 10;
`else
   localparam int FL = 9;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [23:0] bcd_digits = 24'h0;
   logic        busy, done, error, bus_cs, bus_rd, bus_wr;
   logic [4:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   logic [42:0] q[$];
   bit          idle_err = 1'b0;
   int          done_cnt = 0;
   int          nbusy[16];
   int          polls[16];
   logic [7:0]  tx_bytes[$];
   int          rc_cnt = 0;
   int          rc_cur = 0;
   int          rp = 0;

   uart_time_sequencer #(
      .GUARD_CYC(G),
      .POLL_TIMEOUT(PT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .bcd_digits(bcd_digits),
      .busy(busy), .done(done), .error(error),
      .bus_cs(bus_cs), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [42:0] mk(input logic b, d, e, cs, rd, wr,
                                      input logic [4:0] a, input logic [31:0] w);
      return {b, d, e, cs, rd, wr, a, w};
   endfunction

   function automatic logic [7:0] model_char(input logic [23:0] dg, input int c);
      int k;
      logic [3:0] d;
      if (c == 2) return 8'h3A;
      if (c == 5) return 8'h2E;
      if (c == 8) return (FL == 10) ? 8'h0D : 8'h0A;
      if (c == 9) return 8'h0A;
      k = (c < 2) ? c : ((c < 5) ? c - 1 : c - 2);
      d = dg[23 - 4*k -: 4];
      return (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h3F;
   endfunction

   // Whole frame of expected per-cycle outputs, given the busy-poll count scheduled for each character.
   function automatic void gen_frame(input logic [23:0] dg);
      bit to = 1'b0;
      for (int c = 0; c < FL && !to; c++) begin
         q.push_back(mk(1, 0, 0, 1, 0, 1, 5'h08, {24'h0, model_char(dg, c)}));
         q.push_back(mk(1, 0, 0, 1, 0, 1, 5'h10, 32'h1));
         q.push_back(mk(1, 0, 0, 1, 0, 1, 5'h10, 32'h0));
         for (int g = 0; g < G; g++) q.push_back(mk(1, 0, 0, 0, 0, 0, 5'h0, 32'h0));
         if (nbusy[c] >= PT) to = 1'b1;
         for (int p = 0; p < (to ? PT : nbusy[c] + 1); p++) begin
            q.push_back(mk(1, 0, 0, 1, 1, 0, 5'h18, 32'h0));
            q.push_back(mk(1, 0, 0, 0, 0, 0, 5'h0, 32'h0));
         end
      end
      if (!to) q.push_back(mk(0, 1, 0, 0, 0, 0, 5'h0, 32'h0));
      idle_err = to;
   endfunction

   function automatic logic [7:0] lit_basic(input int i);
      logic [7:0] t[10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h2E, 8'h35, 8'h36, 8'h0D, 8'h0A};
      if (FL == 9 && i == 8) return 8'h0A;
      return t[i];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [42:0] act, exp_v;
      act = mk(busy, done, error, bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata);
      if (!rst) begin
         exp_v = 43'h0;
         q.delete();
         idle_err = 1'b0;
      end else if (q.size() > 0) begin
         exp_v = q.pop_front();
      end else begin
         exp_v = mk(0, 0, idle_err, 0, 0, 0, 5'h0, 32'h0);
         if (start) gen_frame(bcd_digits);
      end
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL cycle_compare t=%0t got %h expected %h", $time, act, exp_v);
      end
      if (done) done_cnt++;
   end

   always @(negedge clk) begin : uart_model
      logic [31:0] r;
      if (bus_cs && bus_wr && bus_addr == 5'h08) begin
         rc_cur = rc_cnt;
         rc_cnt++;
         rp = 0;
         tx_bytes.push_back(bus_wdata[7:0]);
      end
      if (bus_cs && bus_rd) begin
         polls[rc_cur & 15]++;
         r = $urandom;
         r[0] = (rp < nbusy[rc_cur & 15]);
         bus_rdata = r;
         rp++;
      end
   end

   task automatic set_nb(input int v);
      for (int i = 0; i < 16; i++) nbusy[i] = v;
   endtask

   task automatic start_frame(input logic [23:0] dg);
      rc_cnt = 0;
      tx_bytes.delete();
      for (int i = 0; i < 16; i++) polls[i] = 0;
      bcd_digits = dg;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (q.size() != 0 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, (q.size() == 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic chk_basic_bytes(input string name);
      chk({name, "_len"}, tx_bytes.size(), FL);
      for (int i = 0; i < FL && i < tx_bytes.size(); i++)
         chk(name, {24'h0, tx_bytes[i]}, {24'h0, lit_basic(i)});
   endtask

   initial begin
      int d0, found;
      logic [23:0] dg;
      set_nb(0);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_cs", bus_cs, 0);
      chk("reset_wdata", bus_wdata, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // basic frame
      d0 = done_cnt;
      start_frame(24'h123456);
      wait_idle("basic_complete");
      chk_basic_bytes("basic_byte");
      chk("basic_done_once", done_cnt - d0, 1);

      // busy polling: five busy reads per character
      set_nb(5);
      d0 = done_cnt;
      start_frame(24'h123456);
      wait_idle("poll_complete");
      for (int c = 0; c < FL; c++) chk("poll_count", polls[c], 6);
      chk("poll_done_once", done_cnt - d0, 1);

      // invalid digit
      set_nb(0);
      start_frame(24'hC23456);
      wait_idle("invalid_complete");
      chk("invalid_first", tx_bytes[0], 8'h3F);
      for (int i = 1; i < FL; i++) chk("invalid_rest", tx_bytes[i], lit_basic(i));

      // timeout on the first character
      set_nb(0);
      nbusy[0] = 100;
      d0 = done_cnt;
      start_frame(24'h123456);
      wait_idle("timeout_complete");
      chk("timeout_polls", polls[0], PT);
      chk("timeout_error", error, 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_done", done_cnt - d0, 0);
      chk("timeout_bytes", tx_bytes.size(), 1);
      nbusy[0] = 0;
      start_frame(24'h123456);
      chk("restart_clears_error", error, 0);
      wait_idle("restart_complete");

      // reset during the tx_wr set cycle
      start_frame(24'h923456);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (bus_wr && bus_addr == 5'h10 && bus_wdata == 32'h1) found = 1;
         else begin @(posedge clk); #1; end
      end
      chk("reset_found_ctrl", found, 1);
      #1 rst = 1'b0;
      #1;
      chk("async_rst_cs", bus_cs, 0);
      chk("async_rst_wr", bus_wr, 0);
      chk("async_rst_busy", busy, 0);
      @(posedge clk); #1 rst = 1'b1;
      start_frame(24'h723456);
      wait_idle("after_reset_complete");
      chk("after_reset_first", tx_bytes[0], 8'h37);

      // second start during GUARD is ignored
      d0 = done_cnt;
      start_frame(24'h123456);
      repeat (3) @(posedge clk);
      #1;
      bcd_digits = 24'h999999;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("dup_start_complete");
      chk_basic_bytes("dup_start_byte");
      chk("dup_start_done_once", done_cnt - d0, 1);
      chk("dup_start_last_lf", tx_bytes[tx_bytes.size() - 1], 8'h0A);

      // randomized frames
      for (int f = 0; f < 10; f++) begin
         dg = 24'($urandom);
         for (int c = 0; c < 16; c++) nbusy[c] = $urandom_range(0, 3);
         if ($urandom_range(0, 4) == 0) nbusy[$urandom_range(0, FL - 1)] = PT + 2;
         start_frame(dg);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #1;
            bcd_digits = 24'($urandom);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         wait_idle("rand_complete");
         for (int i = 0; i < tx_bytes.size(); i++)
            chk("rand_byte", tx_bytes[i], model_char(dg, i));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
